// File: rtl/down_cntr_pkg.sv
// Shared types and constants for the ms countdown timer and its prescaler.
package down_cntr_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam int CMD_W = 3;

  localparam logic [CMD_W-1:0] CMD_HOLD  = 3'b000;
  localparam logic [CMD_W-1:0] CMD_START = 3'b001;
  localparam logic [CMD_W-1:0] CMD_PAUSE = 3'b010;
  localparam logic [CMD_W-1:0] CMD_LOAD  = 3'b011;
  localparam logic [CMD_W-1:0] CMD_CLEAR = 3'b100;

  // clk cycles per ms at the lab clock; up_cntr uses the same value
  localparam int PRESCALE_DEFAULT = 2500;

endpackage

// File: rtl/ms_prescaler.sv
// Mod-PRESCALE cycle counter producing a one-cycle tick per ms.
// Freezes while en=0; clr returns it to zero and wins over en.
module ms_prescaler
  import down_cntr_pkg::*;
#(
  parameter int PRESCALE = PRESCALE_DEFAULT
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clr,
  output logic tick
);

  localparam int CW = (PRESCALE > 2) ? $clog2(PRESCALE) : 1;
  localparam logic [CW-1:0] LAST = CW'(PRESCALE - 1);

  logic [CW-1:0] r_cnt;

  assign tick = en && (r_cnt == LAST);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt <= '0;
    end else if (clr) begin
      r_cnt <= '0;
    end else if (en) begin
      if (r_cnt == LAST) r_cnt <= '0;
      else               r_cnt <= r_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/down_cntr_ms.sv
// Millisecond countdown timer driven by a level-held 3-bit command bus.
//   state | meaning
//   IDLE  | loaded or cleared, waiting for start (start ignored when cnt==0)
//   RUN   | prescaler enabled, cnt decrements once per ms
//   PAUSE | prescaler and cnt frozen, start resumes
//   DONE  | reached zero; only load or clear leave
module down_cntr_ms
  import down_cntr_pkg::*;
#(
  parameter int WIDTH    = 16,
  parameter int PRESCALE = PRESCALE_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [2:0]       cmd,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] cnt_dn_ms,
  output logic             running,
  output logic             done,
  output logic             expired
);

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  state_t           r_state;
  logic [WIDTH-1:0] r_cnt;
  logic             r_running;
  logic             r_done;
  logic             r_expired;

  logic w_clr_cmd;
  logic w_en;
  logic w_tick;
  logic w_terminal;

  // load and clear override everything, pause freezes the prescaler in the same cycle
  assign w_clr_cmd  = (cmd == CMD_CLEAR) || (cmd == CMD_LOAD);
  assign w_en       = (r_state == RUN) && !w_clr_cmd && (cmd != CMD_PAUSE);
  assign w_terminal = w_tick && (r_cnt <= ONE);

  ms_prescaler #(.PRESCALE(PRESCALE)) u_prescaler (
    .clk  (clk),
    .rst  (rst),
    .en   (w_en),
    .clr  (w_clr_cmd || w_terminal),
    .tick (w_tick)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= IDLE;
      r_cnt     <= '0;
      r_running <= 1'b0;
      r_done    <= 1'b0;
      r_expired <= 1'b0;
    end else begin
      r_expired <= 1'b0;
      if (cmd == CMD_CLEAR) begin
        r_state   <= IDLE;
        r_cnt     <= '0;
        r_running <= 1'b0;
        r_done    <= 1'b0;
      end else if (cmd == CMD_LOAD) begin
        r_state   <= IDLE;
        r_cnt     <= load_val;
        r_running <= 1'b0;
        r_done    <= 1'b0;
      end else begin
        case (r_state)
          IDLE: begin
            if (cmd == CMD_START && r_cnt != '0) begin
              r_state   <= RUN;
              r_running <= 1'b1;
            end
          end
          RUN: begin
            if (cmd == CMD_PAUSE) begin
              r_state   <= PAUSE;
              r_running <= 1'b0;
            end else if (w_terminal) begin
              r_state   <= DONE;
              r_cnt     <= '0;
              r_running <= 1'b0;
              r_done    <= 1'b1;
              r_expired <= 1'b1;
            end else if (w_tick) begin
              r_cnt <= r_cnt - ONE;
            end
          end
          PAUSE: begin
            if (cmd == CMD_START) begin
              r_state   <= RUN;
              r_running <= 1'b1;
            end
          end
          DONE: begin
            r_cnt <= '0;
          end
          default: begin
            r_state <= IDLE;
          end
        endcase
      end
    end
  end

  assign cnt_dn_ms = r_cnt;
  assign running   = r_running;
  assign done      = r_done;
  assign expired   = r_expired;

endmodule
